// File: rtl/fractal_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fractal_sync_pkg
//  Description : Shared types for the fractal synchronization node. Holds the
//                source/destination mask enum, the illegal-mask constant and
//                the typedef macro used to build width-parameterized response
//                payloads in client modules.
//  Revision    : 1.0 - initial release
// ============================================================================

// Builds a response payload struct {lvl, id, err} from caller-supplied field
// types so that modules with their own LVL/ID widths can share one layout.
`ifndef FRACTAL_SYNC_TYPEDEF_RSP_T
`define FRACTAL_SYNC_TYPEDEF_RSP_T(rsp_t, lvl_t, id_t) \
    typedef struct packed {                            \
        lvl_t lvl;                                     \
        id_t  id;                                      \
        logic err;                                     \
    } rsp_t;
`endif

package fractal_sync_pkg;

    localparam int unsigned SD_WIDTH = 2;

    // Bit 0 selects the east/north child, bit 1 the west/south child.
    typedef enum logic [SD_WIDTH-1:0] {
        SD_EAST_NORTH = 2'b01,
        SD_WEST_SOUTH = 2'b10,
        SD_BOTH       = 2'b11
    } sd_e;

    // A mask with no destination bit set carries nowhere to deliver to.
    localparam sd_e SD_NONE = sd_e'(2'b00);

    localparam int unsigned DEFAULT_LVL_WIDTH = 4;
    localparam int unsigned DEFAULT_ID_WIDTH  = 8;

    `FRACTAL_SYNC_TYPEDEF_RSP_T(rsp_default_t, logic [DEFAULT_LVL_WIDTH-1:0], logic [DEFAULT_ID_WIDTH-1:0])

endpackage
`default_nettype wire

// File: rtl/fractal_sync_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fractal_sync_rsp_fifo
//  Description : Pointer/count FIFO buffering downlink responses. Exposes the
//                head entry combinationally; full/empty come from the
//                registered count. DEPTH must be a power of two, >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fractal_sync_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr_q;
    logic [PTR_WIDTH-1:0]  rptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  push_eff;
    logic                  pop_eff;

    // Pointers wrap explicitly so a depth of one keeps its pointer at zero.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o   = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;
    assign data_o   = mem_q[rptr_q];

    // Storage, pointers and occupancy; storage is cleared so idle payloads read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_eff) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= next_ptr(wptr_q);
            end
            if (pop_eff) begin
                rptr_q <= next_ptr(rptr_q);
            end
            if (push_eff && !pop_eff) begin
                count_q <= count_q + 1'b1;
            end else if (pop_eff && !push_eff) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fractal_sync_rsp_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : fractal_sync_rsp_splitter
//  Description : Downlink response splitter. Buffers parent responses and
//                delivers each to the east/north port, the west/south port or
//                both, with independent handshakes and in-order delivery.
//                Optional macro FRACTAL_SYNC_RSP_FALLTHROUGH_EN presents a
//                response arriving at an empty buffer in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fractal_sync_rsp_splitter
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LVL_WIDTH  = 4,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [SD_WIDTH-1:0]  rsp_sd_i,
    input  logic [LVL_WIDTH-1:0] rsp_lvl_i,
    input  logic [ID_WIDTH-1:0]  rsp_id_i,
    input  logic                 rsp_err_i,
    output logic                 en_valid_o,
    input  logic                 en_ready_i,
    output logic [LVL_WIDTH-1:0] en_lvl_o,
    output logic [ID_WIDTH-1:0]  en_id_o,
    output logic                 en_err_o,
    output logic                 ws_valid_o,
    input  logic                 ws_ready_i,
    output logic [LVL_WIDTH-1:0] ws_lvl_o,
    output logic [ID_WIDTH-1:0]  ws_id_o,
    output logic                 ws_err_o,
    output logic                 illegal_sd_o
);

    typedef logic [LVL_WIDTH-1:0] lvl_t;
    typedef logic [ID_WIDTH-1:0]  id_t;
    `FRACTAL_SYNC_TYPEDEF_RSP_T(rsp_t, lvl_t, id_t)

    typedef struct packed {
        logic [SD_WIDTH-1:0] sd;
        rsp_t                payload;
    } entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(entry_t);

    entry_t                 in_entry;
    entry_t                 head_entry;
    entry_t                 src_entry;
    logic [ENTRY_WIDTH-1:0] fifo_rdata;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   legal;
    logic                   src_valid;
    logic                   en_hs;
    logic                   ws_hs;
    logic                   en_done;
    logic                   ws_done;
    logic                   src_done;
    logic                   sent_en_q, sent_en_d;
    logic                   sent_ws_q, sent_ws_d;
    logic                   illegal_q, illegal_d;

    assign in_entry.sd          = rsp_sd_i;
    assign in_entry.payload.lvl = rsp_lvl_i;
    assign in_entry.payload.id  = rsp_id_i;
    assign in_entry.payload.err = rsp_err_i;
    assign head_entry           = entry_t'(fifo_rdata);

    // Ready is taken from registered occupancy only, never from a same-cycle pop.
    assign rsp_ready_o = ~fifo_full;
    assign accept      = rsp_valid_i & rsp_ready_o;
    assign legal       = (rsp_sd_i != SD_NONE);

`ifdef FRACTAL_SYNC_RSP_FALLTHROUGH_EN
    // An empty buffer lets the incoming response act as the head this cycle.
    assign src_entry = fifo_empty ? in_entry : head_entry;
    assign src_valid = fifo_empty ? (accept & legal) : 1'b1;
`else
    assign src_entry = head_entry;
    assign src_valid = ~fifo_empty;
`endif

    // A port is offered the head only while its destination bit is still owed.
    assign en_valid_o = src_valid & src_entry.sd[0] & ~sent_en_q;
    assign ws_valid_o = src_valid & src_entry.sd[1] & ~sent_ws_q;
    assign en_lvl_o   = src_entry.payload.lvl;
    assign en_id_o    = src_entry.payload.id;
    assign en_err_o   = src_entry.payload.err;
    assign ws_lvl_o   = src_entry.payload.lvl;
    assign ws_id_o    = src_entry.payload.id;
    assign ws_err_o   = src_entry.payload.err;

    assign en_hs    = en_valid_o & en_ready_i;
    assign ws_hs    = ws_valid_o & ws_ready_i;
    assign en_done  = ~src_entry.sd[0] | sent_en_q | en_hs;
    assign ws_done  = ~src_entry.sd[1] | sent_ws_q | ws_hs;
    assign src_done = src_valid & en_done & ws_done;

    assign fifo_pop = ~fifo_empty & src_done;
`ifdef FRACTAL_SYNC_RSP_FALLTHROUGH_EN
    // A response fully delivered while bypassing never needs to be stored.
    assign fifo_push = accept & legal & ~(fifo_empty & src_done);
`else
    assign fifo_push = accept & legal;
`endif

    // Sent flags accumulate handshakes and clear when the current entry retires.
    always_comb begin
        sent_en_d = sent_en_q | en_hs;
        sent_ws_d = sent_ws_q | ws_hs;
        illegal_d = accept & ~legal;
        if (src_done) begin
            sent_en_d = 1'b0;
            sent_ws_d = 1'b0;
        end
    end

    // Delivery bookkeeping and the registered illegal-mask pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_en_q <= 1'b0;
            sent_ws_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            sent_en_q <= sent_en_d;
            sent_ws_q <= sent_ws_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_sd_o = illegal_q;

    fractal_sync_rsp_fifo #(
        .DATA_WIDTH (ENTRY_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (in_entry),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_rsp_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fractal_sync_rsp_splitter
//  Description : Directed self-checking bench for fractal_sync_rsp_splitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fractal_sync_rsp_splitter;

    localparam int unsigned LVL_WIDTH  = 4;
    localparam int unsigned ID_WIDTH   = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 rsp_valid_i;
    logic                 rsp_ready_o;
    logic [1:0]           rsp_sd_i;
    logic [LVL_WIDTH-1:0] rsp_lvl_i;
    logic [ID_WIDTH-1:0]  rsp_id_i;
    logic                 rsp_err_i;
    logic                 en_valid_o;
    logic                 en_ready_i;
    logic [LVL_WIDTH-1:0] en_lvl_o;
    logic [ID_WIDTH-1:0]  en_id_o;
    logic                 en_err_o;
    logic                 ws_valid_o;
    logic                 ws_ready_i;
    logic [LVL_WIDTH-1:0] ws_lvl_o;
    logic [ID_WIDTH-1:0]  ws_id_o;
    logic                 ws_err_o;
    logic                 illegal_sd_o;

    int checks   = 0;
    int failures = 0;

    fractal_sync_rsp_splitter #(
        .LVL_WIDTH  (LVL_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_ready_o  (rsp_ready_o),
        .rsp_sd_i     (rsp_sd_i),
        .rsp_lvl_i    (rsp_lvl_i),
        .rsp_id_i     (rsp_id_i),
        .rsp_err_i    (rsp_err_i),
        .en_valid_o   (en_valid_o),
        .en_ready_i   (en_ready_i),
        .en_lvl_o     (en_lvl_o),
        .en_id_o      (en_id_o),
        .en_err_o     (en_err_o),
        .ws_valid_o   (ws_valid_o),
        .ws_ready_i   (ws_ready_i),
        .ws_lvl_o     (ws_lvl_o),
        .ws_id_o      (ws_id_o),
        .ws_err_o     (ws_err_o),
        .illegal_sd_o (illegal_sd_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] sd, input logic [3:0] lvl, input logic [7:0] id, input logic err);
        rsp_valid_i = 1'b1;
        rsp_sd_i    = sd;
        rsp_lvl_i   = lvl;
        rsp_id_i    = id;
        rsp_err_i   = err;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valids: got %b expected 00", {en_valid_o, ws_valid_o});
        end
        checks++;
        if (rsp_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", rsp_ready_o);
        end
        checks++;
        if (illegal_sd_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal: got %b expected 0", illegal_sd_o);
        end
        checks++;
        if ({en_lvl_o, en_id_o, en_err_o, ws_lvl_o, ws_id_o, ws_err_o} !== '0) begin
            failures++;
            $display("FAIL reset_payload: en %h/%h/%b ws %h/%h/%b expected zeros",
                     en_lvl_o, en_id_o, en_err_o, ws_lvl_o, ws_id_o, ws_err_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_en();
        en_ready_i = 1'b1;
        ws_ready_i = 1'b0;
        drive(2'b01, 4'd3, 8'h15, 1'b0);
        #1;
        checks++;
        if (en_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_en_latency: en_valid got %b expected 0 in input cycle", en_valid_o);
        end
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, en_lvl_o, en_id_o, ws_valid_o} !== {1'b1, 4'd3, 8'h15, 1'b0}) begin
            failures++;
            $display("FAIL single_en_deliver: en_v=%b lvl=%h id=%h ws_v=%b expected 1 3 15 0",
                     en_valid_o, en_lvl_o, en_id_o, ws_valid_o);
        end
        tick();
        checks++;
        if ({en_valid_o, ws_valid_o, rsp_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL single_en_empty: en_v/ws_v/ready got %b expected 001",
                     {en_valid_o, ws_valid_o, rsp_ready_o});
        end
    endtask

    task automatic test_both_split();
        int en_hs_cnt;
        en_hs_cnt  = 0;
        en_ready_i = 1'b1;
        ws_ready_i = 1'b0;
        drive(2'b11, 4'd5, 8'hA3, 1'b1);
        tick();
        rsp_valid_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ws_valid_o, ws_lvl_o, ws_id_o, ws_err_o} !== {1'b1, 4'd5, 8'hA3, 1'b1}) begin
                failures++;
                $display("FAIL both_ws_hold[%0d]: ws_v=%b lvl=%h id=%h err=%b expected 1 5 a3 1",
                         i, ws_valid_o, ws_lvl_o, ws_id_o, ws_err_o);
            end
            if (en_valid_o && en_ready_i) en_hs_cnt++;
            tick();
        end
        ws_ready_i = 1'b1;
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o} !== 2'b01) begin
            failures++;
            $display("FAIL both_ws_cycle: en_v/ws_v got %b expected 01", {en_valid_o, ws_valid_o});
        end
        tick();
        checks++;
        if ({en_valid_o, ws_valid_o, rsp_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL both_popped: en_v/ws_v/ready got %b expected 001",
                     {en_valid_o, ws_valid_o, rsp_ready_o});
        end
        checks++;
        if (en_hs_cnt !== 1) begin
            failures++;
            $display("FAIL both_en_count: got %0d en handshakes expected 1", en_hs_cnt);
        end
    endtask

    task automatic test_full();
        en_ready_i = 1'b0;
        ws_ready_i = 1'b0;
        drive(2'b01, 4'd1, 8'h01, 1'b0);
        tick();
        drive(2'b10, 4'd2, 8'h02, 1'b0);
        #1;
        checks++;
        if (rsp_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_one_entry_ready: got %b expected 1", rsp_ready_o);
        end
        tick();
        drive(2'b11, 4'd3, 8'h03, 1'b0);
        #1;
        checks++;
        if ({rsp_ready_o, en_valid_o, en_id_o, ws_valid_o} !== {1'b0, 1'b1, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL full_after_two: ready=%b en_v=%b en_id=%h ws_v=%b expected 0 1 01 0",
                     rsp_ready_o, en_valid_o, en_id_o, ws_valid_o);
        end
        tick();
        checks++;
        if (rsp_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_holds: ready got %b expected 0", rsp_ready_o);
        end
        en_ready_i = 1'b1;
        tick();
        checks++;
        if ({rsp_ready_o, ws_valid_o, ws_id_o, en_valid_o} !== {1'b1, 1'b1, 8'h02, 1'b0}) begin
            failures++;
            $display("FAIL full_after_pop: ready=%b ws_v=%b ws_id=%h en_v=%b expected 1 1 02 0",
                     rsp_ready_o, ws_valid_o, ws_id_o, en_valid_o);
        end
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o, ws_id_o} !== {1'b0, 1'b1, 8'h02}) begin
            failures++;
            $display("FAIL full_order_block: en_v=%b ws_v=%b ws_id=%h expected 0 1 02",
                     en_valid_o, ws_valid_o, ws_id_o);
        end
        ws_ready_i = 1'b1;
        tick();
        checks++;
        if ({en_valid_o, en_id_o, ws_valid_o, ws_id_o} !== {1'b1, 8'h03, 1'b1, 8'h03}) begin
            failures++;
            $display("FAIL full_third: en_v=%b en_id=%h ws_v=%b ws_id=%h expected 1 03 1 03",
                     en_valid_o, en_id_o, ws_valid_o, ws_id_o);
        end
        tick();
        checks++;
        if ({en_valid_o, ws_valid_o, rsp_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL full_drained: en_v/ws_v/ready got %b expected 001",
                     {en_valid_o, ws_valid_o, rsp_ready_o});
        end
    endtask

    task automatic test_illegal();
        en_ready_i = 1'b1;
        ws_ready_i = 1'b1;
        drive(2'b00, 4'd7, 8'h77, 1'b0);
        #1;
        checks++;
        if ({rsp_ready_o, illegal_sd_o, en_valid_o, ws_valid_o} !== 4'b1000) begin
            failures++;
            $display("FAIL illegal_accept: ready/ill/en_v/ws_v got %b expected 1000",
                     {rsp_ready_o, illegal_sd_o, en_valid_o, ws_valid_o});
        end
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({illegal_sd_o, en_valid_o, ws_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL illegal_pulse: ill/en_v/ws_v got %b expected 100",
                     {illegal_sd_o, en_valid_o, ws_valid_o});
        end
        tick();
        checks++;
        if ({illegal_sd_o, en_valid_o, ws_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL illegal_single: ill/en_v/ws_v got %b expected 000",
                     {illegal_sd_o, en_valid_o, ws_valid_o});
        end
        // Occupancy must still be zero: exactly two pushes should fill it.
        en_ready_i = 1'b0;
        ws_ready_i = 1'b0;
        drive(2'b01, 4'd1, 8'h21, 1'b0);
        tick();
        drive(2'b01, 4'd1, 8'h22, 1'b0);
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({rsp_ready_o, en_id_o} !== {1'b0, 8'h21}) begin
            failures++;
            $display("FAIL illegal_count: ready=%b en_id=%h expected 0 21", rsp_ready_o, en_id_o);
        end
        en_ready_i = 1'b1;
        tick();
        checks++;
        if ({en_valid_o, en_id_o} !== {1'b1, 8'h22}) begin
            failures++;
            $display("FAIL illegal_second: en_v=%b en_id=%h expected 1 22", en_valid_o, en_id_o);
        end
        tick();
        checks++;
        if ({en_valid_o, rsp_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL illegal_drain: en_v/ready got %b expected 01", {en_valid_o, rsp_ready_o});
        end
    endtask

    task automatic test_reset_mid();
        en_ready_i = 1'b1;
        ws_ready_i = 1'b0;
        drive(2'b11, 4'd4, 8'h44, 1'b0);
        tick();
        rsp_valid_i = 1'b0;
        tick();
        checks++;
        if ({en_valid_o, ws_valid_o, ws_id_o} !== {1'b0, 1'b1, 8'h44}) begin
            failures++;
            $display("FAIL rstmid_half: en_v=%b ws_v=%b ws_id=%h expected 0 1 44",
                     en_valid_o, ws_valid_o, ws_id_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o, rsp_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_immediate: en_v/ws_v/ready got %b expected 001",
                     {en_valid_o, ws_valid_o, rsp_ready_o});
        end
        tick();
        tick();
        rst_ni     = 1'b1;
        en_ready_i = 1'b1;
        ws_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({en_valid_o, ws_valid_o} !== 2'b00) begin
                failures++;
                $display("FAIL rstmid_stale[%0d]: en_v/ws_v got %b expected 00", i, {en_valid_o, ws_valid_o});
            end
            tick();
        end
        ws_ready_i = 1'b0;
        drive(2'b11, 4'd5, 8'h55, 1'b0);
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o, en_id_o} !== {1'b1, 1'b1, 8'h55}) begin
            failures++;
            $display("FAIL rstmid_fresh: en_v=%b ws_v=%b id=%h expected 1 1 55",
                     en_valid_o, ws_valid_o, en_id_o);
        end
        ws_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] id;
        en_ready_i = 1'b1;
        ws_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            id = 8'h30 + 8'(i);
            drive((i % 2 == 1) ? 2'b11 : 2'b01, 4'(i), id, 1'b0);
            #1;
            checks++;
            if (rsp_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rsp_ready_o);
            end
            if (i > 0) begin
                checks++;
                if ({en_valid_o, en_id_o} !== {1'b1, id - 8'd1}) begin
                    failures++;
                    $display("FAIL b2b_stream[%0d]: en_v=%b en_id=%h expected 1 %h",
                             i, en_valid_o, en_id_o, id - 8'd1);
                end
            end
            tick();
        end
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, en_id_o} !== {1'b1, 8'h34}) begin
            failures++;
            $display("FAIL b2b_last: en_v=%b en_id=%h expected 1 34", en_valid_o, en_id_o);
        end
        tick();
        checks++;
        if ({en_valid_o, ws_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle: en_v/ws_v got %b expected 00", {en_valid_o, ws_valid_o});
        end
    endtask

`ifdef FRACTAL_SYNC_RSP_FALLTHROUGH_EN
    task automatic test_fallthrough();
        en_ready_i = 1'b1;
        ws_ready_i = 1'b1;
        drive(2'b11, 4'd6, 8'h66, 1'b0);
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o, en_id_o, ws_id_o} !== {1'b1, 1'b1, 8'h66, 8'h66}) begin
            failures++;
            $display("FAIL ft_same_cycle: en_v=%b ws_v=%b en_id=%h ws_id=%h expected 1 1 66 66",
                     en_valid_o, ws_valid_o, en_id_o, ws_id_o);
        end
        tick();
        rsp_valid_i = 1'b0;
        #1;
        checks++;
        if ({en_valid_o, ws_valid_o, rsp_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL ft_not_stored: en_v/ws_v/ready got %b expected 001",
                     {en_valid_o, ws_valid_o, rsp_ready_o});
        end
    endtask
`endif

    initial begin
        rst_ni      = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_sd_i    = 2'b00;
        rsp_lvl_i   = '0;
        rsp_id_i    = '0;
        rsp_err_i   = 1'b0;
        en_ready_i  = 1'b0;
        ws_ready_i  = 1'b0;
        test_reset();
`ifdef FRACTAL_SYNC_RSP_FALLTHROUGH_EN
        test_fallthrough();
`else
        test_single_en();
        test_both_split();
        test_full();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
